// File: rtl/iz_layer_tdm_pkg.sv
// iz_layer_tdm_pkg: Izhikevich Q-format constants (FRAC=7) and the layer FSM state type.
package iz_pkg;
   localparam int K1 = 5;
   localparam int K2 = 640;
   localparam int K3 = 17920;
   localparam int A = 3;
   localparam int B = 26;
   localparam int C = -8320;
   localparam int D = 1024;
   localparam int VTH = 3840;
   localparam int U_INIT = -1664;
   typedef enum logic [1:0] {IDLE, ACCUM, UPDATE, DONE} state_t;
endpackage

// File: rtl/iz_layer_tdm_if.sv
// iz_layer_tdm_if: step control, weight write port and spike outputs of the layer.
interface iz_layer_tdm_if #(parameter int N_IN = 2, parameter int N_OUT = 4, parameter int WIDTH = 16);
   localparam int AW = N_OUT * N_IN > 1 ? $clog2(N_OUT * N_IN) : 1;
   logic step_start;
   logic [N_IN-1:0] spike_in;
   logic w_we;
   logic [AW-1:0] w_addr;
   logic signed [WIDTH-1:0] w_data;
   logic busy;
   logic step_done;
   logic [N_OUT-1:0] spike_out;
   modport master (output step_start, spike_in, w_we, w_addr, w_data, input busy, step_done, spike_out);
   modport slave (input step_start, spike_in, w_we, w_addr, w_data, output busy, step_done, spike_out);
endinterface

// File: rtl/iz_layer_tdm_neuron_core.sv
// iz_neuron_core: one Euler step of an Izhikevich neuron, saturated, with spike/reset handling.
module iz_neuron_core import iz_pkg::*; #(
   parameter int WIDTH = 16,
   parameter int FRAC = 7,
   parameter int DT_SHIFT = 1
) (
   input  logic signed [WIDTH-1:0] v,
   input  logic signed [WIDTH-1:0] u,
   input  logic signed [WIDTH-1:0] cur,
   output logic signed [WIDTH-1:0] v_next,
   output logic signed [WIDTH-1:0] u_next,
   output logic fire
);
   localparam int W = 2 * WIDTH + 4;
   localparam logic signed [W-1:0] max_w = {{(W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [W-1:0] min_w = {{(W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
   localparam logic signed [W-1:0] k1_w = W'(K1);
   localparam logic signed [W-1:0] k2_w = W'(K2);
   localparam logic signed [W-1:0] k3_w = W'(K3);
   localparam logic signed [W-1:0] a_w = W'(A);
   localparam logic signed [W-1:0] b_w = W'(B);
   localparam logic signed [W-1:0] d_w = W'(D);
   localparam logic signed [WIDTH-1:0] c_n = WIDTH'(C);
   localparam logic signed [WIDTH-1:0] vth_n = WIDTH'(VTH);
   function automatic logic signed [W-1:0] ext(input logic signed [WIDTH-1:0] x);
      return {{(W-WIDTH){x[WIDTH-1]}}, x};
   endfunction
   function automatic logic signed [WIDTH-1:0] sat(input logic signed [W-1:0] x);
      return x > max_w ? max_w[WIDTH-1:0] : x < min_w ? min_w[WIDTH-1:0] : x[WIDTH-1:0];
   endfunction
   logic signed [W-1:0] ve, ue, vv, dv, du;
   logic signed [WIDTH-1:0] v_s, u_s;
   always_comb begin
      ve = ext(v);
      ue = ext(u);
      vv = (ve * ve) >>> FRAC;
      dv = ((k1_w * vv) >>> FRAC) + ((k2_w * ve) >>> FRAC) + k3_w - ue + ext(cur);
      du = (a_w * (((b_w * ve) >>> FRAC) - ue)) >>> FRAC;
      v_s = sat(ve + (dv >>> DT_SHIFT));
      u_s = sat(ue + (du >>> DT_SHIFT));
      fire = v_s >= vth_n;
      v_next = fire ? c_n : v_s;
      u_next = fire ? sat(ext(u_s) + d_w) : u_s;
   end
endmodule

// File: rtl/iz_layer_tdm.sv
// iz_layer_tdm: layer of N_OUT Izhikevich neurons sharing one update core; per step each
// neuron accumulates its weighted input spikes (one input per cycle) and then updates.
module iz_layer_tdm import iz_pkg::*; #(
   parameter int N_IN = 2,
   parameter int N_OUT = 4,
   parameter int WIDTH = 16,
   parameter int FRAC = 7,
   parameter int DT_SHIFT = 1
) (
   input logic clk,
   input logic rst_n,
   iz_layer_tdm_if.slave bus
);
   localparam int NW = N_OUT * N_IN;
   localparam int AW = NW > 1 ? $clog2(NW) : 1;
   localparam int IW = N_IN > 1 ? $clog2(N_IN) : 1;
   localparam int JW = N_OUT > 1 ? $clog2(N_OUT) : 1;
   state_t state, state_nxt;
   logic [IW-1:0] in_idx;
   logic [JW-1:0] nr_idx;
   logic [AW-1:0] w_idx;
   logic [N_IN-1:0] spk;
   logic [N_OUT-1:0] spk_acc, spike_out;
   logic signed [WIDTH-1:0] v [N_OUT];
   logic signed [WIDTH-1:0] u [N_OUT];
   logic signed [WIDTH-1:0] w [NW];
   logic signed [WIDTH-1:0] cur, add, cur_sum, v_next, u_next;
   logic signed [WIDTH:0] sum;
   logic last_in, last_nr, fire;
   iz_neuron_core #(.WIDTH(WIDTH), .FRAC(FRAC), .DT_SHIFT(DT_SHIFT)) core (
      .v(v[nr_idx]), .u(u[nr_idx]), .cur(cur), .v_next(v_next), .u_next(u_next), .fire(fire)
   );
   always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nxt;
   always_comb begin
      last_in = in_idx == IW'(N_IN - 1);
      last_nr = nr_idx == JW'(N_OUT - 1);
      state_nxt = state == IDLE ? (bus.step_start ? ACCUM : IDLE) :
                  state == ACCUM ? (last_in ? UPDATE : ACCUM) :
                  state == UPDATE ? (last_nr ? DONE : ACCUM) : IDLE;
      bus.busy = state != IDLE;
      bus.step_done = state == DONE;
      bus.spike_out = spike_out;
      w_idx = AW'(int'(nr_idx) * N_IN + int'(in_idx));
      add = spk[in_idx] ? w[w_idx] : '0;
      sum = {cur[WIDTH-1], cur} + {add[WIDTH-1], add};
      // clamp on signed overflow of the running current
      cur_sum = sum[WIDTH] == sum[WIDTH-1] ? sum[WIDTH-1:0] : {sum[WIDTH], {(WIDTH-1){~sum[WIDTH]}}};
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_idx <= '0;
         nr_idx <= '0;
         spk <= '0;
         spk_acc <= '0;
         spike_out <= '0;
         cur <= '0;
         for (int k = 0; k < N_OUT; k++) begin
            v[k] <= WIDTH'(C);
            u[k] <= WIDTH'(U_INIT);
         end
         for (int k = 0; k < NW; k++) w[k] <= '0;
      end else begin
         if (state == IDLE && bus.w_we && int'(bus.w_addr) < NW) w[bus.w_addr] <= bus.w_data;
         if (state == IDLE && bus.step_start) begin
            spk <= bus.spike_in;
            in_idx <= '0;
            nr_idx <= '0;
            cur <= '0;
            spk_acc <= '0;
         end
         if (state == ACCUM) begin
            cur <= cur_sum;
            in_idx <= last_in ? '0 : in_idx + 1'b1;
         end
         if (state == UPDATE) begin
            v[nr_idx] <= v_next;
            u[nr_idx] <= u_next;
            spk_acc[nr_idx] <= fire;
            cur <= '0;
            nr_idx <= nr_idx + 1'b1;
            if (last_nr) spike_out <= spk_acc | (N_OUT'(fire) << nr_idx);
         end
      end
   end
endmodule

// File: tb/tb_iz_layer_tdm.sv
// tb_iz_layer_tdm: directed vectors and corner sequences for iz_layer_tdm at default parameters.
module tb_iz_layer_tdm;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   iz_layer_tdm_if #(.N_IN(2), .N_OUT(4), .WIDTH(16)) bus ();
   iz_layer_tdm #(.N_IN(2), .N_OUT(4), .WIDTH(16), .FRAC(7), .DT_SHIFT(1)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   typedef struct {
      logic [1:0] spk;
      int addr;
      int data;
      logic [3:0] exp_out;
   } vec_t;
   vec_t vec [4];
   int n_chk = 0;
   int n_fail = 0;
   longint mv [4];
   longint mu [4];
   longint mw [8];

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic longint sat16(input longint x);
      return x > 32767 ? 32767 : x < -32768 ? -32768 : x;
   endfunction

   task automatic model_reset();
      for (int j = 0; j < 4; j++) begin
         mv[j] = -8320;
         mu[j] = -1664;
      end
      for (int k = 0; k < 8; k++) mw[k] = 0;
   endtask

   task automatic model_step(input logic [1:0] s, output logic [3:0] sp);
      longint c, vv, dv, vn, un;
      sp = '0;
      for (int j = 0; j < 4; j++) begin
         c = 0;
         for (int i = 0; i < 2; i++) if (s[i]) c = sat16(c + mw[j*2+i]);
         vv = (mv[j] * mv[j]) >>> 7;
         dv = ((5 * vv) >>> 7) + ((640 * mv[j]) >>> 7) + 17920 - mu[j] + c;
         vn = sat16(mv[j] + (dv >>> 1));
         un = sat16(mu[j] + (((3 * (((26 * mv[j]) >>> 7) - mu[j])) >>> 7) >>> 1));
         if (vn >= 3840) begin
            sp[j] = 1'b1;
            mv[j] = -8320;
            mu[j] = sat16(un + 1024);
         end else begin
            mv[j] = vn;
            mu[j] = un;
         end
      end
   endtask

   task automatic check_state(input string tag);
      for (int j = 0; j < 4; j++) begin
         check($sformatf("%s v%0d", tag, j), dut.v[j], mv[j]);
         check($sformatf("%s u%0d", tag, j), dut.u[j], mu[j]);
      end
      for (int k = 0; k < 8; k++) check($sformatf("%s w%0d", tag, k), dut.w[k], mw[k]);
   endtask

   task automatic write_w(input int addr, input int data);
      bus.w_we = 1'b1;
      bus.w_addr = 3'(addr);
      bus.w_data = 16'(data);
      @(negedge clk);
      bus.w_we = 1'b0;
      mw[addr] = data;
   endtask

   // Launch a step (optionally with a same-cycle weight write) and watch 20 cycles after acceptance.
   task automatic run_step(input logic [1:0] s, input logic wr, input int addr, input int data,
                           input int inj_k, output int done_at, output int n_done, output int n_busy,
                           output longint cur3, output longint cur6);
      bus.spike_in = s;
      bus.step_start = 1'b1;
      bus.w_we = wr;
      bus.w_addr = 3'(addr);
      bus.w_data = 16'(data);
      @(negedge clk);
      bus.step_start = 1'b0;
      bus.w_we = 1'b0;
      done_at = 0;
      n_done = 0;
      n_busy = 0;
      cur3 = 0;
      cur6 = 0;
      for (int k = 1; k <= 20; k++) begin
         if (bus.busy) n_busy++;
         if (bus.step_done) begin
            n_done++;
            if (done_at == 0) done_at = k;
         end
         if (k == 3) cur3 = dut.cur;
         if (k == 6) cur6 = dut.cur;
         if (k == inj_k) begin
            bus.step_start = 1'b1;
            bus.w_we = 1'b1;
            bus.w_addr = 3'd0;
            bus.w_data = 16'sd123;
            bus.spike_in = 2'b11;
         end
         @(negedge clk);
         bus.step_start = 1'b0;
         bus.w_we = 1'b0;
      end
   endtask

   task automatic check_timing(input string tag, input int done_at, input int n_done, input int n_busy);
      check({tag, " done_at"}, done_at, 13);
      check({tag, " done_pulses"}, n_done, 1);
      check({tag, " busy_cycles"}, n_busy, 13);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int done_at, n_done, n_busy, nd;
      longint cur3, cur6;
      logic [3:0] exp;
      bus.step_start = 1'b0;
      bus.spike_in = '0;
      bus.w_we = 1'b0;
      bus.w_addr = '0;
      bus.w_data = '0;
      vec[0] = '{2'b01, 0, 32767, 4'b0001};
      vec[1] = '{2'b01, 2, 32767, 4'b0011};
      vec[2] = '{2'b10, 7, 32767, 4'b1000};
      vec[3] = '{2'b11, 5, 16384, 4'b1011};
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("reset busy", bus.busy, 0);
      check("reset step_done", bus.step_done, 0);
      check("reset spike_out", bus.spike_out, 0);
      check_state("reset");
      for (int n = 0; n < 100; n++) begin
         run_step(2'b11, 1'b0, 0, 0, 0, done_at, n_done, n_busy, cur3, cur6);
         model_step(2'b11, exp);
         check_timing($sformatf("zero_w step%0d", n), done_at, n_done, n_busy);
         check($sformatf("zero_w spike_out%0d", n), bus.spike_out, 0);
         if (n % 10 == 9) check_state($sformatf("zero_w step%0d", n));
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int r = 0; r < 4; r++) begin
         run_step(vec[r].spk, 1'b1, vec[r].addr, vec[r].data, 0, done_at, n_done, n_busy, cur3, cur6);
         mw[vec[r].addr] = vec[r].data;
         model_step(vec[r].spk, exp);
         check_timing($sformatf("vec%0d", r), done_at, n_done, n_busy);
         check($sformatf("vec%0d spike_out", r), bus.spike_out, vec[r].exp_out);
         check_state($sformatf("vec%0d", r));
      end
      run_step(2'b00, 1'b0, 0, 0, 3, done_at, n_done, n_busy, cur3, cur6);
      model_step(2'b00, exp);
      check_timing("busy_inject", done_at, n_done, n_busy);
      check("busy_inject spike_out", bus.spike_out, exp);
      check_state("busy_inject");
      write_w(1, 32767);
      write_w(2, -32768);
      write_w(3, -32768);
      run_step(2'b11, 1'b0, 0, 0, 0, done_at, n_done, n_busy, cur3, cur6);
      model_step(2'b11, exp);
      check_timing("sat", done_at, n_done, n_busy);
      check("sat cur_pos", cur3, 32767);
      check("sat cur_neg", cur6, -32768);
      check("sat spike_out", bus.spike_out, exp);
      check("sat n0_fired", bus.spike_out[0], 1);
      check_state("sat");
      bus.spike_in = 2'b11;
      bus.step_start = 1'b1;
      @(negedge clk);
      bus.step_start = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      check("midreset busy", bus.busy, 0);
      check("midreset step_done", bus.step_done, 0);
      check("midreset spike_out", bus.spike_out, 0);
      check("midreset cur", dut.cur, 0);
      check_state("midreset");
      nd = 0;
      for (int k = 0; k < 20; k++) begin
         if (bus.step_done) nd++;
         @(negedge clk);
      end
      check("midreset no_done", nd, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/iz_layer_tdm.md
IZ_LAYER_TDM -- requirements
Module: iz_layer_tdm

Interface
REQ-001 Parameter N_IN, default 2, number of input spike channels (1..16).
REQ-002 Parameter N_OUT, default 4, number of Izhikevich neurons in the layer (1..64).
REQ-003 Parameter WIDTH, default 16, signed fixed-point width of v, u, weights and current.
REQ-004 Parameter FRAC, default 7, fractional bits of the fixed-point format.
REQ-005 Parameter DT_SHIFT, default 1, integration step dt = 2^-DT_SHIFT ms.
REQ-006 clk  input  1  clock.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 step_start  input  1  request one simulation time step; sampled only in IDLE.
REQ-009 spike_in  input  N_IN  input spikes, latched on the cycle step_start is accepted.
REQ-010 w_we  input  1  weight write enable; honoured only in IDLE.
REQ-011 w_addr  input  clog2(N_OUT*N_IN)  weight index = j*N_IN + i (neuron j, input i).
REQ-012 w_data  input  WIDTH  signed weight value.
REQ-013 busy  output  1  high from the cycle after acceptance through the step_done cycle.
REQ-014 step_done  output  1  one-cycle pulse at the end of a time step.
REQ-015 spike_out  output  N_OUT  spikes of the last completed step, held until the next step_done.

Function
REQ-016 The FSM SHALL have states IDLE, ACCUM, UPDATE, DONE; IDLE->ACCUM on step_start, ACCUM->UPDATE after N_IN cycles, UPDATE->ACCUM (next neuron) or ->DONE after neuron N_OUT-1, DONE->IDLE.
REQ-017 ACCUM SHALL add w[j][i] to current I_j for input i, one input per cycle, only when the latched spike_in[i]=1; I_j SHALL saturate at the signed WIDTH limits.
REQ-018 UPDATE SHALL compute in one cycle, with intermediates at 2*WIDTH+4 bits, products arithmetic-shifted right by FRAC, and results saturated to WIDTH: v' = v + (K1*v*v + K2*v + K3 - u + I) >>> DT_SHIFT; u' = u + (A*(B*v - u)) >>> DT_SHIFT.
REQ-019 If v' >= VTH, the neuron SHALL spike: v <= C, u <= u' + D, spike bit j = 1; otherwise v <= v', u <= u', spike bit j = 0.
REQ-020 Latency: with step_start accepted at cycle t, step_done SHALL pulse at cycle t + N_OUT*(N_IN+1) + 1 (13 cycles at the defaults), and spike_out SHALL update on that same cycle.
REQ-021 step_start while busy SHALL be ignored, with no queueing.
REQ-022 w_we while busy SHALL be ignored; w_addr >= N_OUT*N_IN SHALL be ignored.
REQ-023 step_start and w_we in the same IDLE cycle: the write SHALL complete and the step SHALL use the new weight.
REQ-024 Neuron state v, u SHALL persist across steps; only reset or a spike modifies it outside UPDATE.

Reset
REQ-025 Under reset: FSM=IDLE, busy=0, step_done=0, spike_out=0, every v=C, every u=U_INIT, every weight=0, every I=0.
REQ-026 Reset asserted mid-step SHALL abort the step with no step_done, and all state SHALL take the REQ-025 values.

Structure
REQ-027 A shared package iz_pkg SHALL hold Q-format constants at FRAC=7: K1=5 (0.04), K2=640 (5), K3=17920 (140), A=3 (0.02), B=26 (0.2), C=-8320 (-65), D=1024 (8), VTH=3840 (30), U_INIT=-1664 (-13), plus the FSM state typedef.
REQ-028 The combinational update of REQ-018/019 SHALL be a sub-module iz_neuron_core, instantiated once and time-shared across all neurons.
REQ-029 v, u and the weights SHALL be register arrays indexed by a neuron counter and an input counter.

Verification
REQ-030 Reset, then idle for 20 cycles -> spike_out=0, busy=0, step_done=0, and all v=-8320, all u=-1664.
REQ-031 Defaults, one step_start -> busy for 13 cycles, step_done high exactly at t+13, one pulse.
REQ-032 All weights 0, spike_in=2'b11, 100 steps -> spike_out=0 on every step_done.
REQ-033 w[0][0]=32767, spike_in=2'b01, repeated steps -> I_0 saturates at 32767, neuron 0 spikes within 5 steps, after which v_0=-8320 and u_0 has increased by 1024; neurons 1..3 stay 0.
REQ-034 step_start and w_we pulsed while busy -> ignored: no extra step_done, and weight read-back is unchanged.
REQ-035 rst_n low for 1 cycle at mid-step (t+6) -> no step_done, all outputs and state at REQ-025 values on the next cycle.
